// File: rtl/ccu_sync_en_gen_pkg.sv
// ccu_sync_en_gen_pkg: channel state encoding and reset-time period/offset defaults for the sync-enable generator
package ccu_sync_en_gen_pkg;
  typedef enum logic [1:0] {CH_IDLE, CH_ARM, CH_RUN, CH_DRAIN} ch_state_t;
  localparam int CCU_DEF_PER_M1 = 15;
  localparam int CCU_DEF_S2C_OFS = 0;
  localparam int CCU_DEF_C2S_OFS = 2;
endpackage

// File: rtl/ccu_sync_en_gen_ch_fsm.sv
// ccu_sync_en_gen_ch_fsm: one channel's boundary-aligned start/stop FSM (boundary/ch_en/ch_stop/hit_* in; running and registered pulses out)
module ccu_sync_en_gen_ch_fsm
  import ccu_sync_en_gen_pkg::*;
(
  input  logic gclk,
  input  logic rst_por_,
  input  logic boundary,
  input  logic ch_en,
  input  logic ch_stop,
  input  logic hit_s2c,
  input  logic hit_c2s,
  output logic running,
  output logic s2c_pulse,
  output logic c2s_pulse
);
  ch_state_t state, state_nxt;
  logic run_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE:  state_nxt = ch_en && !ch_stop ? CH_ARM : CH_IDLE;
      CH_ARM:   state_nxt = !ch_en ? CH_IDLE : boundary ? CH_RUN : CH_ARM;
      CH_RUN:   state_nxt = !ch_en || ch_stop ? CH_DRAIN : CH_RUN;
      CH_DRAIN: state_nxt = boundary ? CH_IDLE : CH_DRAIN;
      default:  state_nxt = CH_IDLE;
    endcase
  end
  assign run_nxt = state_nxt == CH_RUN || state_nxt == CH_DRAIN;
  always_ff @(posedge gclk or negedge rst_por_) begin
    if (!rst_por_) begin
      state     <= CH_IDLE;
      running   <= 1'b0;
      s2c_pulse <= 1'b0;
      c2s_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      running   <= run_nxt;
      s2c_pulse <= run_nxt && hit_s2c;
      c2s_pulse <= run_nxt && hit_c2s;
    end
  end
endmodule

// File: rtl/ccu_sync_en_gen.sv
// ccu_sync_en_gen: shared-phase multi-channel cmp<->slow sync pulse generator (cfg_* programs period/offsets at boundaries, ch_* start/stop channels)
module ccu_sync_en_gen
  import ccu_sync_en_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int DEF_PER_M1  = CCU_DEF_PER_M1,
  parameter int DEF_S2C_OFS = CCU_DEF_S2C_OFS,
  parameter int DEF_C2S_OFS = CCU_DEF_C2S_OFS
) (
  input  logic              gclk,
  input  logic              rst_por_,
  input  logic              cfg_req,
  input  logic [CNT_W-1:0]  cfg_per_m1,
  input  logic [CNT_W-1:0]  cfg_s2c_ofs,
  input  logic [CNT_W-1:0]  cfg_c2s_ofs,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              cfg_busy,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_stop,
  output logic [NUM_CH-1:0] ch_running,
  output logic [NUM_CH-1:0] slow_cmp_sync_en,
  output logic [NUM_CH-1:0] cmp_slow_sync_en,
  output logic [CNT_W-1:0]  phase_cnt
);
  logic [CNT_W-1:0] per_m1, s2c_ofs, c2s_ofs;
  logic [CNT_W-1:0] pend_per_m1, pend_s2c_ofs, pend_c2s_ofs;
  logic [CNT_W-1:0] phase_nxt, s2c_nxt, c2s_nxt;
  logic boundary, apply, cfg_bad, hit_s2c, hit_c2s;
  assign boundary  = phase_cnt == per_m1;
  assign apply     = boundary && cfg_busy;
  assign phase_nxt = boundary ? '0 : phase_cnt + 1'b1;
  assign s2c_nxt   = apply ? pend_s2c_ofs : s2c_ofs;
  assign c2s_nxt   = apply ? pend_c2s_ofs : c2s_ofs;
  assign hit_s2c   = phase_nxt == s2c_nxt;
  assign hit_c2s   = phase_nxt == c2s_nxt;
  assign cfg_bad   = cfg_per_m1 == '0 || cfg_s2c_ofs > cfg_per_m1 || cfg_c2s_ofs > cfg_per_m1 || cfg_busy;
  always_ff @(posedge gclk or negedge rst_por_) begin
    if (!rst_por_) begin
      phase_cnt    <= '0;
      per_m1       <= CNT_W'(DEF_PER_M1);
      s2c_ofs      <= CNT_W'(DEF_S2C_OFS);
      c2s_ofs      <= CNT_W'(DEF_C2S_OFS);
      pend_per_m1  <= '0;
      pend_s2c_ofs <= '0;
      pend_c2s_ofs <= '0;
      cfg_ack      <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_busy     <= 1'b0;
    end else begin
      phase_cnt <= phase_nxt;
      cfg_ack   <= apply;
      cfg_err   <= cfg_req && cfg_bad;
      cfg_busy  <= (cfg_busy && !apply) || (cfg_req && !cfg_bad);
      if (apply) begin
        per_m1  <= pend_per_m1;
        s2c_ofs <= pend_s2c_ofs;
        c2s_ofs <= pend_c2s_ofs;
      end
      if (cfg_req && !cfg_bad) begin
        pend_per_m1  <= cfg_per_m1;
        pend_s2c_ofs <= cfg_s2c_ofs;
        pend_c2s_ofs <= cfg_c2s_ofs;
      end
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ccu_sync_en_gen_ch_fsm u_fsm (
      .gclk      (gclk),
      .rst_por_  (rst_por_),
      .boundary  (boundary),
      .ch_en     (ch_en[i]),
      .ch_stop   (ch_stop[i]),
      .hit_s2c   (hit_s2c),
      .hit_c2s   (hit_c2s),
      .running   (ch_running[i]),
      .s2c_pulse (slow_cmp_sync_en[i]),
      .c2s_pulse (cmp_slow_sync_en[i])
    );
  end
endmodule

// File: tb/tb_ccu_sync_en_gen.sv
// tb_ccu_sync_en_gen: directed stimulus with a cycle scoreboard for the sync-enable generator
module tb_ccu_sync_en_gen;
  localparam int N = 4;
  localparam int W = 4;
  logic gclk = 1'b0;
  logic rst_por_ = 1'b0;
  logic cfg_req = 1'b0;
  logic [W-1:0] cfg_per_m1 = '0, cfg_s2c_ofs = '0, cfg_c2s_ofs = '0;
  logic cfg_ack, cfg_err, cfg_busy;
  logic [N-1:0] ch_en = '0, ch_stop = '0;
  logic [N-1:0] ch_running, slow_cmp_sync_en, cmp_slow_sync_en;
  logic [W-1:0] phase_cnt;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [W-1:0] ph;
    logic ack, err, busy;
    logic [N-1:0] run, s2c, c2s;
  } obs_t;
  obs_t sb[$];
  int m_ph, m_per, m_s2c, m_c2s, p_per, p_s2c, p_c2s;
  bit m_busy;
  int m_st[N];
  ccu_sync_en_gen dut (
    .gclk(gclk), .rst_por_(rst_por_), .cfg_req(cfg_req),
    .cfg_per_m1(cfg_per_m1), .cfg_s2c_ofs(cfg_s2c_ofs), .cfg_c2s_ofs(cfg_c2s_ofs),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_busy(cfg_busy),
    .ch_en(ch_en), .ch_stop(ch_stop), .ch_running(ch_running),
    .slow_cmp_sync_en(slow_cmp_sync_en), .cmp_slow_sync_en(cmp_slow_sync_en),
    .phase_cnt(phase_cnt)
  );
  always #5 gclk = ~gclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_ph = 0; m_per = 15; m_s2c = 0; m_c2s = 2;
    p_per = 0; p_s2c = 0; p_c2s = 0; m_busy = 0;
    for (int i = 0; i < N; i++) m_st[i] = 0;
    sb.delete();
  endtask
  task automatic step();
    obs_t e, o;
    bit bnd, app;
    int nph;
    e = '0;
    bnd = m_ph == m_per;
    app = bnd && m_busy;
    e.err = cfg_req && (cfg_per_m1 == 0 || cfg_s2c_ofs > cfg_per_m1 || cfg_c2s_ofs > cfg_per_m1 || m_busy);
    e.ack = app;
    e.busy = (m_busy && !app) || (cfg_req && !e.err);
    if (app) begin m_per = p_per; m_s2c = p_s2c; m_c2s = p_c2s; end
    if (cfg_req && !e.err) begin p_per = cfg_per_m1; p_s2c = cfg_s2c_ofs; p_c2s = cfg_c2s_ofs; end
    m_busy = e.busy;
    nph = bnd ? 0 : (m_ph + 1) % (1 << W);
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 0 && ch_en[i] && !ch_stop[i]) m_st[i] = 1;
      else if (m_st[i] == 1) m_st[i] = !ch_en[i] ? 0 : (bnd ? 2 : 1);
      else if (m_st[i] == 2 && (!ch_en[i] || ch_stop[i])) m_st[i] = 3;
      else if (m_st[i] == 3 && bnd) m_st[i] = 0;
      e.run[i] = m_st[i] >= 2;
      e.s2c[i] = e.run[i] && nph == m_s2c;
      e.c2s[i] = e.run[i] && nph == m_c2s;
    end
    e.ph = nph[W-1:0];
    m_ph = nph;
    sb.push_back(e);
    @(posedge gclk);
    #1;
    o = {phase_cnt, cfg_ack, cfg_err, cfg_busy, ch_running, slow_cmp_sync_en, cmp_slow_sync_en};
    e = sb.pop_front();
    chk("sb_phase_cnt", o.ph, e.ph);
    chk("sb_cfg_ack", o.ack, e.ack);
    chk("sb_cfg_err", o.err, e.err);
    chk("sb_cfg_busy", o.busy, e.busy);
    chk("sb_ch_running", o.run, e.run);
    chk("sb_slow_cmp", o.s2c, e.s2c);
    chk("sb_cmp_slow", o.c2s, e.c2s);
  endtask
  task automatic run_to_phase(input int ph, input int budget);
    int k = 0;
    while (phase_cnt != ph[W-1:0] && k < budget) begin step(); k++; end
    chk("run_to_phase", phase_cnt, ph);
  endtask
  task automatic run_to_ack(input int budget);
    int k = 0;
    while (cfg_ack !== 1'b1 && k < budget) begin step(); k++; end
    chk("run_to_ack", cfg_ack, 1);
  endtask
  task automatic send_cfg(input int per, input int s2c, input int c2s);
    cfg_req = 1'b1;
    cfg_per_m1 = per[W-1:0];
    cfg_s2c_ofs = s2c[W-1:0];
    cfg_c2s_ofs = c2s[W-1:0];
    step();
    cfg_req = 1'b0;
  endtask
  task automatic hard_reset();
    #2 rst_por_ = 1'b0;
    #1;
    chk("rst_async_outs", {phase_cnt, cfg_ack, cfg_err, cfg_busy, ch_running, slow_cmp_sync_en, cmp_slow_sync_en}, 0);
    model_reset();
    @(posedge gclk);
    #1;
    chk("rst_hold_outs", {phase_cnt, cfg_ack, cfg_err, cfg_busy, ch_running, slow_cmp_sync_en, cmp_slow_sync_en}, 0);
    rst_por_ = 1'b1;
  endtask
  initial begin
    logic seen;
    model_reset();
    repeat (2) @(posedge gclk);
    #1;
    chk("reset_outs", {phase_cnt, cfg_ack, cfg_err, cfg_busy, ch_running, slow_cmp_sync_en, cmp_slow_sync_en}, 0);
    rst_por_ = 1'b1;
    ch_en = 4'b0001;
    repeat (15) step();
    chk("t1_armed_no_pulse", slow_cmp_sync_en, 0);
    chk("t1_armed_not_running", ch_running, 0);
    step();
    chk("t1_first_phase", phase_cnt, 0);
    chk("t1_first_s2c", slow_cmp_sync_en, 4'b0001);
    repeat (2) step();
    chk("t1_first_c2s", cmp_slow_sync_en, 4'b0001);
    repeat (14) step();
    chk("t1_period16_s2c", slow_cmp_sync_en, 4'b0001);
    repeat (5) step();
    send_cfg(7, 3, 5);
    chk("t2_busy", cfg_busy, 1);
    run_to_ack(20);
    chk("t2_ack_phase0", phase_cnt, 0);
    chk("t2_ack_busy_clr", cfg_busy, 0);
    repeat (3) step();
    chk("t2_s2c_ph3", slow_cmp_sync_en, 4'b0001);
    repeat (2) step();
    chk("t2_c2s_ph5", cmp_slow_sync_en, 4'b0001);
    repeat (6) step();
    chk("t2_spacing8_phase", phase_cnt, 3);
    chk("t2_spacing8_s2c", slow_cmp_sync_en, 4'b0001);
    send_cfg(0, 0, 0);
    chk("t3_err_per0", cfg_err, 1);
    send_cfg(7, 9, 1);
    chk("t3_err_ofs", cfg_err, 1);
    send_cfg(11, 1, 1);
    chk("t3_accept_no_err", cfg_err, 0);
    chk("t3_accept_busy", cfg_busy, 1);
    send_cfg(5, 0, 0);
    chk("t3_err_busy", cfg_err, 1);
    chk("t3_still_busy", cfg_busy, 1);
    run_to_ack(20);
    step();
    chk("t3_equal_ofs_s2c", slow_cmp_sync_en, 4'b0001);
    chk("t3_equal_ofs_c2s", cmp_slow_sync_en, 4'b0001);
    send_cfg(15, 0, 12);
    run_to_ack(30);
    ch_en = 4'b0011;
    step();
    run_to_phase(0, 40);
    chk("t4_both_running", ch_running, 4'b0011);
    run_to_phase(4, 10);
    ch_stop = 4'b0010;
    step();
    ch_stop = 4'b0000;
    run_to_phase(12, 20);
    chk("t4_drain_pulse", cmp_slow_sync_en, 4'b0011);
    run_to_phase(15, 10);
    chk("t4_drain_running", ch_running, 4'b0011);
    step();
    chk("t4_ch1_idle", ch_running, 4'b0001);
    chk("t4_ch0_s2c", slow_cmp_sync_en, 4'b0001);
    ch_en = 4'b0001;
    send_cfg(7, 3, 5);
    chk("t5_busy", cfg_busy, 1);
    run_to_phase(9, 20);
    chk("t5_busy_ph9", cfg_busy, 1);
    hard_reset();
    seen = 1'b0;
    repeat (40) begin step(); seen = seen | cfg_ack; end
    chk("t5_no_ack", seen, 0);
    chk("t5_default_period", phase_cnt, 8);
    run_to_phase(15, 20);
    send_cfg(7, 1, 2);
    chk("t6_bnd_phase0", phase_cnt, 0);
    chk("t6_bnd_no_ack", cfg_ack, 0);
    chk("t6_bnd_busy", cfg_busy, 1);
    repeat (15) step();
    chk("t6_full_period_ph", phase_cnt, 15);
    chk("t6_full_period_no_ack", cfg_ack, 0);
    step();
    chk("t6_late_ack", cfg_ack, 1);
    ch_en = 4'b0101;
    ch_stop = 4'b0100;
    step();
    ch_en = 4'b0001;
    ch_stop = 4'b0000;
    seen = 1'b0;
    repeat (20) begin step(); seen = seen | ch_running[2]; end
    chk("t6_stop_wins", seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
